// File: rtl/gb_frame_sequencer.sv
// gb_frame_sequencer
//
// Game Boy APU frame sequencer. It divides the APU master clock down to the 512 Hz
// frame rate and walks an 8-step frame. Each step can emit single-cycle enable
// pulses for the length counters (256 Hz), the channel-1 sweep unit (128 Hz) and
// the volume envelopes (64 Hz).
//
// Step schedule (s = step being executed):
//   s : 0 1 2 3 4 5 6 7
//   clk_length   : x . x . x . x .
//   clk_sweep    : . . x . . . x .
//   clk_envelope : . . . . . . . x
//
// A tick executes step s. The pulses for s are registered, so they are high for
// the one clk after the tick edge. frame_step already shows s+1 in that cycle.
// Pulses for the same step can be high together (steps 2 and 6).
//
// Build option:
//   GB_FS_EXT_DIV_EN  When defined, the internal prescaler is removed. A tick is
//                     taken on each falling edge of div_bit (DIV bit 4) while
//                     apu_enable is high, and DIV_COUNT is unused. When undefined,
//                     div_bit is ignored.
//
// Parameters:
//   DIV_COUNT     master clocks per frame step (>= 2). The default of 8192 gives
//                 4194304 Hz / 512 Hz.
//
// Ports:
//   clk           APU master clock
//   rst_n         asynchronous active-low reset
//   apu_enable    NR52 bit 7. While low, the sequencer is forced to idle.
//   div_bit       DIV timer bit 4. Used only with GB_FS_EXT_DIV_EN.
//   clk_length    one-cycle pulse on steps 0, 2, 4 and 6
//   clk_sweep     one-cycle pulse on steps 2 and 6
//   clk_envelope  one-cycle pulse on step 7
//   frame_step    index of the next step to execute (0..7)

module gb_frame_sequencer #(
  parameter int unsigned DIV_COUNT = 8192
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       apu_enable,
  input  logic       div_bit,
  output logic       clk_length,
  output logic       clk_sweep,
  output logic       clk_envelope,
  output logic [2:0] frame_step
);

  // Tick source: the frame sequencer advances one step when tick is high
  logic tick;

`ifdef GB_FS_EXT_DIV_EN

  // External DIV source. div_bit_q is the previous sample of div_bit.
  // It follows div_bit on every cycle, whatever apu_enable is. This way a
  // falling edge seen right after enable is judged against the real
  // history, not a stale value.
  logic div_bit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_bit_q <= 1'b0;
    end else begin
      div_bit_q <= div_bit;
    end
  end

  // A CPU write to DIV that drops bit 4 from 1 to 0 also lands here. It
  // produces one extra step, as the real hardware does.
  assign tick = apu_enable & div_bit_q & ~div_bit;

`else

  // Internal prescaler: counts 0..DIV_COUNT-1 and wraps.
  localparam int unsigned CntW = (DIV_COUNT > 2) ? $clog2(DIV_COUNT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DIV_COUNT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            unused_div_bit;

  assign unused_div_bit = div_bit;

  assign tick = apu_enable && (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q;
    if (!apu_enable) begin
      // Restart from zero, so the first tick after enable is DIV_COUNT cycles later
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`endif

  // ---------------------------------------------------------------------------
  // Frame step state and registered pulses
  // ---------------------------------------------------------------------------
  logic [2:0] step_q, step_d;
  logic       len_q, len_d;
  logic       sweep_q, sweep_d;
  logic       env_q, env_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q  <= 3'd0;
      len_q   <= 1'b0;
      sweep_q <= 1'b0;
      env_q   <= 1'b0;
    end else begin
      step_q  <= step_d;
      len_q   <= len_d;
      sweep_q <= sweep_d;
      env_q   <= env_d;
    end
  end

  // Next-state: advance on tick with the natural 3-bit wrap 7 -> 0
  always_comb begin
    step_d = step_q;
    if (!apu_enable) begin
      step_d = 3'd0;
    end else if (tick) begin
      step_d = step_q + 3'd1;
    end
  end

  // Pulse decode for the step being executed. The pulses are zero on every
  // non-tick edge, so each pulse lasts exactly one cycle.
  always_comb begin
    len_d   = 1'b0;
    sweep_d = 1'b0;
    env_d   = 1'b0;
    if (tick) begin
      len_d   = ~step_q[0];
      sweep_d = (step_q == 3'd2) || (step_q == 3'd6);
      env_d   = (step_q == 3'd7);
    end
  end

  assign clk_length   = len_q;
  assign clk_sweep    = sweep_q;
  assign clk_envelope = env_q;
  assign frame_step   = step_q;

  // ---------------------------------------------------------------------------
  // Structural properties of the schedule
  // ---------------------------------------------------------------------------
  // No pulse may stay high for two consecutive cycles.
  a_pulse_single: assert property (@(posedge clk) disable iff (!rst_n)
    (clk_length | clk_sweep | clk_envelope) |=> !(clk_length | clk_sweep | clk_envelope));

  // Sweep steps are a subset of length steps.
  a_sweep_with_length: assert property (@(posedge clk) disable iff (!rst_n)
    clk_sweep |-> clk_length);

  // The envelope step has no other pulse.
  a_env_alone: assert property (@(posedge clk) disable iff (!rst_n)
    clk_envelope |-> !(clk_length || clk_sweep));

endmodule

// File: tb/tb_gb_frame_sequencer.sv
// Bench for gb_frame_sequencer, built with DIV_COUNT = 4.
// A behavioural model counts enabled cycles and ticks arithmetically and is
// compared against the DUT on every falling clock edge. Directed scenarios add
// hand-computed literal expectations.

module tb_gb_frame_sequencer;

  localparam int unsigned D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       apu_enable = 1'b0;
  logic       div_bit = 1'b0;
  logic       clk_length, clk_sweep, clk_envelope;
  logic [2:0] frame_step;

  int errors = 0;
  int checks = 0;
  bit cmp_on = 1'b0;

  gb_frame_sequencer #(.DIV_COUNT(D)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .apu_enable   (apu_enable),
    .div_bit      (div_bit),
    .clk_length   (clk_length),
    .clk_sweep    (clk_sweep),
    .clk_envelope (clk_envelope),
    .frame_step   (frame_step)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: m_n = enabled edges since restart, m_t = ticks since restart.
  // A tick executes step (m_t-1) mod 8. The next step is m_t mod 8.
  // ---------------------------------------------------------------------------
  int         m_n = 0;
  int         m_t = 0;
  logic       m_len = 1'b0, m_sw = 1'b0, m_env = 1'b0, m_divq = 1'b0;
  logic [2:0] m_step = 3'd0;

  always @(posedge clk or negedge rst_n) begin
    int n_nx;
    int t_nx;
    int s;
    bit tk;
    if (!rst_n) begin
      m_n <= 0; m_t <= 0; m_len <= 1'b0; m_sw <= 1'b0; m_env <= 1'b0;
      m_step <= 3'd0; m_divq <= 1'b0;
    end else begin
      n_nx = 0;
      t_nx = 0;
      tk = 1'b0;
`ifdef GB_FS_EXT_DIV_EN
      m_divq <= div_bit;
      tk = apu_enable && m_divq && !div_bit;
`else
      if (apu_enable) begin
        n_nx = m_n + 1;
        tk = (n_nx % D) == 0;
      end
`endif
      if (apu_enable) t_nx = tk ? m_t + 1 : m_t;
      s = (t_nx + 7) % 8;
      m_n    <= n_nx;
      m_t    <= t_nx;
      m_len  <= tk && (s % 2 == 0);
      m_sw   <= tk && (s == 2 || s == 6);
      m_env  <= tk && (s == 7);
      m_step <= 3'(t_nx % 8);
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("model_length", int'(clk_length), int'(m_len));
      chk("model_sweep", int'(clk_sweep), int'(m_sw));
      chk("model_envelope", int'(clk_envelope), int'(m_env));
      chk("model_step", int'(frame_step), int'(m_step));
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed helpers
  // ---------------------------------------------------------------------------
  task automatic chk_idle(input string name);
    chk({name, "_len"}, int'(clk_length), 0);
    chk({name, "_sweep"}, int'(clk_sweep), 0);
    chk({name, "_env"}, int'(clk_envelope), 0);
    chk({name, "_step"}, int'(frame_step), 0);
  endtask

  // Walk 32 cycles after enable and check the hand table of one frame.
  task automatic run_sched(input string name);
    logic [7:0] el;
    logic [7:0] es;
    logic [7:0] ee;
    int k;
    el = 8'b0101_0101;  // ticks 1,3,5,7
    es = 8'b0100_0100;  // ticks 3,7
    ee = 8'b1000_0000;  // tick 8
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (i % 4 == 0) begin
        k = i / 4;
        chk({name, "_len"}, int'(clk_length), int'(el[k-1]));
        chk({name, "_sweep"}, int'(clk_sweep), int'(es[k-1]));
        chk({name, "_env"}, int'(clk_envelope), int'(ee[k-1]));
        chk({name, "_step"}, int'(frame_step), k % 8);
      end else begin
        chk({name, "_gap"}, int'(clk_length | clk_sweep | clk_envelope), 0);
      end
    end
  endtask

  task automatic wait_step(input int v);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      @(negedge clk);
      if (frame_step == 3'(v)) found = 1'b1;
    end
    chk("wait_step_found", int'(found), 1);
  endtask

  initial begin
    int nl;
    int ns;
    int ne;
    int wsw;
    #1 rst_n = 1'b0;
    cmp_on = 1'b1;
    #2 chk_idle("reset_state");
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

`ifdef GB_FS_EXT_DIV_EN
    // DIV bit toggles with a period of 8 clk: 8 falling edges in 64 cycles.
    @(negedge clk); #1 apu_enable = 1'b1;
    nl = 0; ns = 0; ne = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      nl += int'(clk_length); ns += int'(clk_sweep); ne += int'(clk_envelope);
      #1 if (i % 4 == 0) div_bit = ~div_bit;
    end
    chk("ext_len_count", nl, 4);
    chk("ext_sweep_count", ns, 2);
    chk("ext_env_count", ne, 1);
    apu_enable = 1'b0;
    nl = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i > 0) nl += int'(clk_length | clk_sweep | clk_envelope);
      #1 if (i % 4 == 0) div_bit = ~div_bit;
    end
    chk("ext_disabled_pulses", nl, 0);
    chk("ext_disabled_step", int'(frame_step), 0);
`else
    // Scenario 1: pulse schedule
    @(negedge clk); #1 apu_enable = 1'b1;
    run_sched("sched");

    // Disable mid-frame at step 5, for 10 clk
    wait_step(5);
    #1 apu_enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_idle("disabled");
    end
    #1 apu_enable = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i < 4) begin
        chk("reen_gap", int'(clk_length | clk_sweep | clk_envelope), 0);
      end else begin
        chk("reen_len", int'(clk_length), 1);
        chk("reen_sweep", int'(clk_sweep), 0);
        chk("reen_env", int'(clk_envelope), 0);
        chk("reen_step", int'(frame_step), 1);
      end
    end

    // Asynchronous reset between edges at step 6
    wait_step(6);
    #1 rst_n = 1'b0;
    #1 chk_idle("async_reset");
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    run_sched("post_reset");

    // Long run: 256 enabled cycles, and the sweep count in each 8*D window
    @(negedge clk); #1 apu_enable = 1'b0;
    @(negedge clk); #1 apu_enable = 1'b1;
    nl = 0; ns = 0; ne = 0; wsw = 0;
    for (int i = 1; i <= 256; i++) begin
      @(negedge clk);
      nl += int'(clk_length); ns += int'(clk_sweep); ne += int'(clk_envelope);
      wsw += int'(clk_sweep);
      if (i % (8 * D) == 0) begin
        chk("frame_sweep_count", wsw, 2);
        wsw = 0;
      end
    end
    chk("long_len_count", nl, 32);
    chk("long_sweep_count", ns, 16);
    chk("long_env_count", ne, 8);
`endif

    cmp_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gb_frame_sequencer.md
Name: gb_frame_sequencer

Overview:
- Generates the 512 Hz DIV-APU frame sequencer for the APU.
- Emits single-cycle enable pulses on clk: clk_length at 256 Hz, clk_sweep at 128 Hz, clk_envelope at 64 Hz.
- These are the tick sources consumed by the channel length counters, the channel-1 sweep function (its clk_sweep input) and the volume envelopes.
- Sits at APU top level between the master clock domain and all channel blocks.

Parameters:
DIV_COUNT, 8192, master clocks per frame-sequencer step (4194304 Hz / 512 Hz); legal range >= 2.

Ports:
clk  input  1  APU master clock
rst_n  input  1  asynchronous active-low reset
apu_enable  input  1  NR52 bit 7; low holds sequencer idle
div_bit  input  1  DIV timer bit 4; used only when GB_FS_EXT_DIV_EN is defined, otherwise ignored
clk_length  output  1  one-cycle pulse, steps 0,2,4,6
clk_sweep  output  1  one-cycle pulse, steps 2,6
clk_envelope  output  1  one-cycle pulse, step 7
frame_step  output  3  index of the next step to execute (0..7)

Behaviour:
- Reset (rst_n low, asynchronous): prescaler=0, frame_step=0, all pulse outputs 0, div_bit history register=0.
- Prescaler: counter of width $clog2(DIV_COUNT), counts 0..DIV_COUNT-1 and wraps to 0.
  - "tick" is combinational: counter==DIV_COUNT-1 and apu_enable.
- On the rising clk edge where tick=1:
  - Pulse outputs are registered from the current frame_step (s): clk_length=(s[0]==0), clk_sweep=(s==2 or s==6), clk_envelope=(s==7).
  - frame_step <= s+1, wrapping 7 -> 0 (3-bit natural wrap).
- Latency: pulses are high for exactly one clk, the cycle after the terminal count. frame_step already shows s+1 during that pulse cycle.
- On every other edge, all pulse outputs are 0. Pulses are never high two consecutive cycles, provided DIV_COUNT >= 2.
- Multiple pulses may be coincident (step 2/6: length+sweep both high). Consumers must accept simultaneous pulses.
- apu_enable low: on each edge, synchronously forces prescaler=0, frame_step=0 and all pulses=0.
  - A pulse already registered completes its single cycle; no further pulses are generated.
- apu_enable rising: counting starts from 0. The first tick occurs DIV_COUNT cycles later and executes step 0 (length only).
- Reset mid-operation: immediate clear; restart identical to the post-reset sequence.
- Period check: one full 8-step frame = 8*DIV_COUNT clk, containing 4 length, 2 sweep and 1 envelope pulse.

Optional Feature:
GB_FS_EXT_DIV_EN
- Defined:
  - The prescaler is removed. tick = apu_enable and falling edge of div_bit, detected against a registered copy div_bit_q, which updates every cycle regardless of apu_enable.
  - Pulse registration, latency and step decode are unchanged.
  - DIV_COUNT is unused.
  - A DIV reset by the CPU that drops div_bit from 1 to 0 produces an extra step, matching hardware.
- Not defined: internal prescaler as above; div_bit is ignored and carries no logic.

Test Plan:
- Pulse schedule. Setup: DIV_COUNT=4; reset; apu_enable=1 held for 32 clk. Required:
  - Pulses at clk 4,8,...,32 after enable.
  - clk_length on ticks 1,3,5,7; clk_sweep on ticks 3,7; clk_envelope on tick 8.
  - frame_step sequence 1,2,...,7,0.
- Long-run counts: DIV_COUNT=4, 256 clk enabled -> exactly 32 clk_length, 16 clk_sweep, 8 clk_envelope. Each pulse is 1 cycle wide.
- Disable mid-frame: disable at frame_step=5 for 10 clk, then re-enable.
  - While disabled: no pulses; frame_step=0.
  - After re-enable: first pulse 4 clk later is clk_length only; frame_step=1.
- Reset mid-frame: assert rst_n=0 asynchronously, between edges, at frame_step=6 -> all outputs 0 immediately; the post-release sequence is identical to scenario 1.
- Sweep integration: drive gb_sweepFunction clk_sweep from this block; trigger with pace=1, decreasing, shift=2, frequency=64.
  - Shadow frequency updates only on clk_sweep pulses: 2 updates per 8*DIV_COUNT clk.
- With GB_FS_EXT_DIV_EN:
  - Toggle div_bit with period 8 clk, apu_enable=1: one tick per falling edge, pulse appears 1 clk after the edge, schedule as in scenario 1.
  - With apu_enable=0 and div_bit still toggling: no pulses.
